// File: rtl/init_seq_responder.sv
// Bring-up sequencer: waits for init_flag, holds the datapath in soft reset, then
// enables each lock-in stage in turn via en/ack and raises sys_ready after settling.
module init_seq_responder #(
  parameter int NUM_STAGES  = 4,
  parameter int RST_HOLD    = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_flag,
  input  logic [31:0]           settle_cycles,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic                  stage_rst_n,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [2:0]            stage_idx,
  output logic                  sys_ready,
  output logic                  timeout_err
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    EN,
    SETTLE,
    READY,
    FAULT
  } state_t;

  state_t                  state_reg;
  logic [HOLD_W-1:0]       hold_cnt_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic [31:0]             settle_cnt_reg;
  logic                    stage_rst_n_reg;
  logic [NUM_STAGES-1:0]   stage_en_reg;
  logic [2:0]              stage_idx_reg;
  logic                    sys_ready_reg;
  logic                    timeout_err_reg;

  logic [NUM_STAGES-1:0]   idx_onehot;
  logic                    cur_ack;
  logic                    cur_en_set;

  // One-hot decode of the awaited stage keeps all stage_en/stage_ack indexing width-safe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
      assign idx_onehot[gi] = (stage_idx_reg == 3'(gi));
    end
  endgenerate

  assign cur_ack    = |(stage_ack & idx_onehot);
  assign cur_en_set = |(stage_en_reg & idx_onehot);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      settle_cnt_reg  <= '0;
      stage_rst_n_reg <= 1'b0;
      stage_en_reg    <= '0;
      stage_idx_reg   <= '0;
      sys_ready_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else if (state_reg != IDLE && !init_flag) begin
      // Abort from anywhere; timeout_err is deliberately left untouched.
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      settle_cnt_reg  <= '0;
      stage_rst_n_reg <= 1'b0;
      stage_en_reg    <= '0;
      stage_idx_reg   <= '0;
      sys_ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          stage_rst_n_reg <= 1'b0;
          if (init_flag) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
          end
        end

        HOLD: begin
          stage_rst_n_reg <= 1'b0;
          if (hold_cnt_reg == HOLD_LAST) begin
            stage_rst_n_reg <= 1'b1;
            stage_idx_reg   <= '0;
            to_cnt_reg      <= '0;
            state_reg       <= EN;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        EN: begin
          stage_en_reg <= stage_en_reg | idx_onehot;
          if (cur_ack) begin
            to_cnt_reg <= '0;
            if (stage_idx_reg == LAST_IDX) begin
              settle_cnt_reg <= '0;
              state_reg      <= SETTLE;
            end else begin
              stage_idx_reg <= stage_idx_reg + 3'd1;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            timeout_err_reg <= 1'b1;
            stage_en_reg    <= '0;
            stage_rst_n_reg <= 1'b0;
            state_reg       <= FAULT;
          end else if (cur_en_set) begin
            // The timeout window opens once the stage's enable is actually driven.
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        SETTLE: begin
          if (settle_cnt_reg >= settle_cycles) begin
            sys_ready_reg <= 1'b1;
            state_reg     <= READY;
          end else if (settle_cnt_reg != '1) begin
            settle_cnt_reg <= settle_cnt_reg + 32'd1;
          end
        end

        READY: begin
          sys_ready_reg <= 1'b1;
        end

        FAULT: begin
          stage_en_reg    <= '0;
          stage_rst_n_reg <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign stage_rst_n = stage_rst_n_reg;
  assign stage_en    = stage_en_reg;
  assign stage_idx   = stage_idx_reg;
  assign sys_ready   = sys_ready_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_init_seq_responder.sv
// Directed bench for init_seq_responder: nominal bring-up, timeout, tied acks,
// ack-on-timeout boundary, aborts and asynchronous reset.
module tb_init_seq_responder;

  logic        clk;
  logic        rst;
  logic        init_flag;
  logic [31:0] settle_cycles;
  logic [3:0]  stage_ack;
  logic        stage_rst_n;
  logic [3:0]  stage_en;
  logic [2:0]  stage_idx;
  logic        sys_ready;
  logic        timeout_err;

  int chk_cnt = 0;
  int err_cnt = 0;

  init_seq_responder #(
    .NUM_STAGES (4),
    .RST_HOLD   (16),
    .ACK_TIMEOUT(1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_flag    (init_flag),
    .settle_cycles(settle_cycles),
    .stage_ack    (stage_ack),
    .stage_rst_n  (stage_rst_n),
    .stage_en     (stage_en),
    .stage_idx    (stage_idx),
    .sys_ready    (sys_ready),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic expect_outs(input string tag, input logic rn, input logic [3:0] en,
                             input logic [2:0] idx, input logic rdy, input logic err);
    check({tag, ".rst_n"}, 32'(stage_rst_n), 32'(rn));
    check({tag, ".en"},    32'(stage_en),    32'(en));
    check({tag, ".idx"},   32'(stage_idx),   32'(idx));
    check({tag, ".ready"}, 32'(sys_ready),   32'(rdy));
    check({tag, ".err"},   32'(timeout_err), 32'(err));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] mask;

  initial begin
    rst = 1'b0;
    init_flag = 1'b0;
    stage_ack = 4'h0;
    settle_cycles = 32'd100;
    step(3);
    expect_outs("reset", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step(2);
    expect_outs("idle", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);

    // Nominal: acks arrive on the 5th edge after each enable
    init_flag = 1'b1;
    step(16);
    check("t1.hold_rst_n", 32'(stage_rst_n), 32'd0);
    step(1);
    check("t1.rst_n_rise", 32'(stage_rst_n), 32'd1);
    check("t1.en_pre", 32'(stage_en), 32'd0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      mask = 4'((1 << (i + 1)) - 1);
      check($sformatf("t1.en%0d", i), 32'(stage_en), 32'(mask));
      check($sformatf("t1.idx%0d", i), 32'(stage_idx), i);
      step(4);
      check($sformatf("t1.wait%0d", i), 32'(stage_idx), i);
      stage_ack[i] = 1'b1;
      step(1);
      if (i < 3) begin
        check($sformatf("t1.adv%0d", i), 32'(stage_idx), i + 1);
        step(1);
      end
    end
    step(100);
    check("t1.settle_wait", 32'(sys_ready), 32'd0);
    step(1);
    expect_outs("t1.ready", 1'b1, 4'hF, 3'd3, 1'b1, 1'b0);
    stage_ack = 4'h0;
    step(3);
    check("t1.ack_drop_ready", 32'(sys_ready), 32'd1);
    check("t1.ack_drop_en", 32'(stage_en), 32'hF);
    init_flag = 1'b0;
    step(1);
    expect_outs("t5.abort_ready", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);

    // Acks tied high, no settle
    stage_ack = 4'hF;
    settle_cycles = 32'd0;
    init_flag = 1'b1;
    step(17);
    check("t3.rst_n", 32'(stage_rst_n), 32'd1);
    check("t3.en_pre", 32'(stage_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      mask = 4'((1 << (i + 1)) - 1);
      check($sformatf("t3.en%0d", i), 32'(stage_en), 32'(mask));
      check($sformatf("t3.rdy%0d", i), 32'(sys_ready), 32'd0);
    end
    step(1);
    check("t3.ready", 32'(sys_ready), 32'd1);
    init_flag = 1'b0;
    step(1);

    // settle_cycles lowered below the running count mid-settle
    settle_cycles = 32'd1000;
    init_flag = 1'b1;
    step(21);
    check("t3b.en", 32'(stage_en), 32'hF);
    step(10);
    check("t3b.not_ready", 32'(sys_ready), 32'd0);
    settle_cycles = 32'd3;
    step(1);
    check("t3b.ready_now", 32'(sys_ready), 32'd1);
    init_flag = 1'b0;
    step(1);

    // Abort during SETTLE
    settle_cycles = 32'd50;
    init_flag = 1'b1;
    step(26);
    check("t5a.in_settle_en", 32'(stage_en), 32'hF);
    check("t5a.in_settle_rdy", 32'(sys_ready), 32'd0);
    init_flag = 1'b0;
    step(1);
    expect_outs("t5a.abort", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    step(60);
    check("t5a.stay_idle", 32'(sys_ready), 32'd0);

    // Abort during EN with stage_idx=2
    stage_ack = 4'h0;
    settle_cycles = 32'd0;
    init_flag = 1'b1;
    step(18);
    check("t5b.en0", 32'(stage_en), 32'h1);
    stage_ack[0] = 1'b1;
    step(1);
    check("t5b.idx1", 32'(stage_idx), 32'd1);
    stage_ack[1] = 1'b1;
    step(1);
    check("t5b.idx2", 32'(stage_idx), 32'd2);
    step(1);
    check("t5b.en2", 32'(stage_en), 32'h7);
    init_flag = 1'b0;
    step(1);
    expect_outs("t5b.abort", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);

    // Timeout on stage 2
    stage_ack = 4'b0011;
    init_flag = 1'b1;
    step(20);
    check("t2.en2_rise", 32'(stage_en), 32'h7);
    step(1023);
    check("t2.pre_err", 32'(timeout_err), 32'd0);
    check("t2.pre_en", 32'(stage_en), 32'h7);
    step(1);
    check("t2.err", 32'(timeout_err), 32'd1);
    check("t2.en", 32'(stage_en), 32'd0);
    check("t2.rst_n", 32'(stage_rst_n), 32'd0);
    step(5);
    check("t2.hold_err", 32'(timeout_err), 32'd1);
    check("t2.hold_en", 32'(stage_en), 32'd0);
    init_flag = 1'b0;
    step(1);
    check("t2.idle_err", 32'(timeout_err), 32'd1);
    stage_ack = 4'hF;
    init_flag = 1'b1;
    step(17);
    check("t2.reinit_rst_n", 32'(stage_rst_n), 32'd1);
    step(4);
    check("t2.reinit_en", 32'(stage_en), 32'hF);
    step(1);
    expect_outs("t2.reinit_ready", 1'b1, 4'hF, 3'd3, 1'b1, 1'b1);

    // Ack on the final timeout cycle wins
    init_flag = 1'b0;
    step(1);
    stage_ack = 4'b0001;
    init_flag = 1'b1;
    step(18);
    check("t4.idx1", 32'(stage_idx), 32'd1);
    step(1);
    check("t4.en1", 32'(stage_en), 32'h3);
    step(1023);
    check("t4.pre_en", 32'(stage_en), 32'h3);
    stage_ack[1] = 1'b1;
    step(1);
    check("t4.idx2", 32'(stage_idx), 32'd2);
    check("t4.rst_n", 32'(stage_rst_n), 32'd1);
    step(1);
    check("t4.en2", 32'(stage_en), 32'h7);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    expect_outs("t6.async", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    step(2);
    check("t6.after_rst_n", 32'(stage_rst_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
